series_sequencer: RTL and testbench



---
 rtl/series_sequencer.sv | 98 +++++++++
 tb/tb_series_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/series_sequencer.sv
// Control sequencer for the iterative series-evaluation datapath: arm, init,
// bounded term accumulation, multi-cycle finalise, and a done/ack result hold.
module series_sequencer #(
  parameter int TERM_W       = 4,
  parameter int MAX_TERMS    = 8,
  parameter int FINAL_CYCLES = 1,
  localparam int FC_W        = $clog2(FINAL_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              abort,
  input  logic              ack,
  output logic [2:0]        state,
  output logic              init_en,
  output logic              accum_en,
  output logic              final_en,
  output logic [TERM_W-1:0] term_idx,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_INIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(MAX_TERMS - 1);
  localparam logic [FC_W-1:0]   FC_LOAD   = FC_W'(FINAL_CYCLES);

  state_e            state_q;
  logic [TERM_W-1:0] term_q;
  logic              ovr_q;
  logic [FC_W-1:0]   fcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      term_q  <= '0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_q <= S_ARM;
        S_ARM:   if (!start) state_q <= S_INIT;
        S_INIT: begin
          term_q  <= '0;
          ovr_q   <= 1'b0;
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          // stop outranks the term limit, so a stop on the last term is not an overrun
          if (stop) begin
            state_q <= S_FINAL;
            fcnt_q  <= FC_LOAD;
          end else if (term_q == LAST_TERM) begin
            state_q <= S_FINAL;
            fcnt_q  <= FC_LOAD;
            ovr_q   <= 1'b1;
          end else begin
            term_q <= term_q + 1'b1;
          end
        end
        S_FINAL: begin
          if (fcnt_q <= FC_W'(1)) begin
            state_q <= S_DONE;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        S_DONE:  if (ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign init_en  = (state_q == S_INIT);
  assign accum_en = (state_q == S_ACCUM);
  assign final_en = (state_q == S_FINAL);
  assign term_idx = term_q;
  assign busy     = (state_q == S_ARM) || (state_q == S_INIT) ||
                    (state_q == S_ACCUM) || (state_q == S_FINAL);
  assign done     = (state_q == S_DONE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_series_sequencer.sv
// Directed bench: default instance plus a FINAL_CYCLES=3 instance on shared inputs.
module tb_series_sequencer;
  logic clk = 1'b0;
  logic reset, start, stop, abort, ack;

  logic [2:0] st0, st1;
  logic ie0, ae0, fe0, bz0, dn0, ov0;
  logic ie1, ae1, fe1, bz1, dn1, ov1;
  logic [3:0] ti0, ti1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  series_sequencer u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort), .ack(ack),
    .state(st0), .init_en(ie0), .accum_en(ae0), .final_en(fe0), .term_idx(ti0),
    .busy(bz0), .done(dn0), .overrun(ov0)
  );

  series_sequencer #(.FINAL_CYCLES(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .abort(abort), .ack(ack),
    .state(st1), .init_en(ie1), .accum_en(ae1), .final_en(fe1), .term_idx(ti1),
    .busy(bz1), .done(dn1), .overrun(ov1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // one-cycle start pulse, leaves both instances in ACCUM with term_idx 0
  task automatic go_accum();
    start = 1'b1; tick();
    start = 1'b0; tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({st0, ie0, ae0, fe0, bz0, dn0, ov0, ti0} !== {3'd0, 6'b0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_state: got st=%0d ie=%b ae=%b fe=%b bz=%b dn=%b ov=%b ti=%0d, want all 0",
               st0, ie0, ae0, fe0, bz0, dn0, ov0, ti0);
    end
  endtask

  task automatic test_basic_run();
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (st0 !== 3'd1 || bz0 !== 1'b1) begin
        n_err++; $display("FAIL basic_arm[%0d]: got st=%0d bz=%b, want 1 1", i, st0, bz0);
      end
    end
    start = 1'b0; tick();
    n_vec++;
    if (st0 !== 3'd2 || ie0 !== 1'b1 || ae0 !== 1'b0) begin
      n_err++; $display("FAIL basic_init: got st=%0d ie=%b ae=%b, want 2 1 0", st0, ie0, ae0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ae0 !== 1'b1 || ti0 !== 4'(i)) begin
        n_err++; $display("FAIL basic_accum[%0d]: got ae=%b ti=%0d, want 1 %0d", i, ae0, ti0, i);
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_vec++;
    if (st0 !== 3'd4 || fe0 !== 1'b1 || ae0 !== 1'b0 || ti0 !== 4'd2) begin
      n_err++; $display("FAIL basic_final: got st=%0d fe=%b ae=%b ti=%0d, want 4 1 0 2", st0, fe0, ae0, ti0);
    end
    tick();
    n_vec++;
    if (st0 !== 3'd5 || dn0 !== 1'b1 || ov0 !== 1'b0 || bz0 !== 1'b0 || ti0 !== 4'd2) begin
      n_err++; $display("FAIL basic_done: got st=%0d dn=%b ov=%b bz=%b ti=%0d, want 5 1 0 0 2",
                        st0, dn0, ov0, bz0, ti0);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_vec++;
    if (st0 !== 3'd0 || dn0 !== 1'b0) begin
      n_err++; $display("FAIL basic_ack: got st=%0d dn=%b, want 0 0", st0, dn0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start = 1'b1; tick();
    start = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (ae0 !== 1'b1 || ti0 !== 4'(i)) begin
        n_err++; $display("FAIL ovr_accum[%0d]: got ae=%b ti=%0d, want 1 %0d", i, ae0, ti0, i);
      end
    end
    tick();
    n_vec++;
    if (st0 !== 3'd4 || ov0 !== 1'b1 || ti0 !== 4'd7) begin
      n_err++; $display("FAIL ovr_final: got st=%0d ov=%b ti=%0d, want 4 1 7", st0, ov0, ti0);
    end
    tick();
    n_vec++;
    if (st0 !== 3'd5 || ov0 !== 1'b1) begin
      n_err++; $display("FAIL ovr_done: got st=%0d ov=%b, want 5 1", st0, ov0);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_vec++;
    if (st0 !== 3'd0 || ov0 !== 1'b1) begin
      n_err++; $display("FAIL ovr_idle_hold: got st=%0d ov=%b, want 0 1", st0, ov0);
    end
    start = 1'b1; tick(); start = 1'b0; tick();
    n_vec++;
    if (st0 !== 3'd2 || ov0 !== 1'b1) begin
      n_err++; $display("FAIL ovr_init_entry: got st=%0d ov=%b, want 2 1", st0, ov0);
    end
    tick();
    n_vec++;
    if (st0 !== 3'd3 || ov0 !== 1'b0) begin
      n_err++; $display("FAIL ovr_cleared: got st=%0d ov=%b, want 3 0", st0, ov0);
    end
  endtask

  task automatic test_stop_last_final3();
    do_reset();
    go_accum();
    repeat (7) tick();
    n_vec++;
    if (ti0 !== 4'd7 || ae0 !== 1'b1) begin
      n_err++; $display("FAIL last_term: got ti=%0d ae=%b, want 7 1", ti0, ae0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_vec++;
    if (st0 !== 3'd4 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
      n_err++; $display("FAIL stop_wins: got st=%0d ov0=%b ov1=%b, want 4 0 0", st0, ov0, ov1);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (fe1 !== 1'b1 || st1 !== 3'd4) begin
        n_err++; $display("FAIL final3[%0d]: got fe=%b st=%0d, want 1 4", i, fe1, st1);
      end
      tick();
    end
    n_vec++;
    if (st1 !== 3'd5 || fe1 !== 1'b0 || dn1 !== 1'b1 || ti1 !== 4'd7) begin
      n_err++; $display("FAIL final3_done: got st=%0d fe=%b dn=%b ti=%0d, want 5 0 1 7", st1, fe1, dn1, ti1);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    go_accum();
    repeat (4) tick();
    abort = 1'b1; stop = 1'b1; tick(); abort = 1'b0; stop = 1'b0;
    n_vec++;
    if (st0 !== 3'd0 || bz0 !== 1'b0 || dn0 !== 1'b0 || ov0 !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got st=%0d bz=%b dn=%b ov=%b, want 0 0 0 0", st0, bz0, dn0, ov0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (dn0 !== 1'b0 || st0 !== 3'd0) begin
        n_err++; $display("FAIL abort_nodone[%0d]: got dn=%b st=%0d, want 0 0", i, dn0, st0);
      end
    end
  endtask

  task automatic test_reset_in_final();
    do_reset();
    go_accum();
    stop = 1'b1; tick(); stop = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++;
    if ({st1, ie1, ae1, fe1, bz1, dn1, ov1, ti1} !== {3'd0, 6'b0, 4'd0}) begin
      n_err++; $display("FAIL reset_final: got st=%0d fe=%b bz=%b dn=%b, want all 0", st1, fe1, bz1, dn1);
    end
  endtask

  task automatic test_done_hold();
    do_reset();
    go_accum();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      stop = i[0]; start = ~i[0];
      tick();
      n_vec++;
      if (st0 !== 3'd5 || dn0 !== 1'b1) begin
        n_err++; $display("FAIL done_hold[%0d]: got st=%0d dn=%b, want 5 1", i, st0, dn0);
      end
    end
    // start held across the ack: IDLE first, then re-armed
    stop = 1'b0; start = 1'b1; ack = 1'b1; tick(); ack = 1'b0;
    n_vec++;
    if (st0 !== 3'd0 || dn0 !== 1'b0) begin
      n_err++; $display("FAIL done_ack: got st=%0d dn=%b, want 0 0", st0, dn0);
    end
    tick();
    n_vec++;
    if (st0 !== 3'd1) begin
      n_err++; $display("FAIL back_to_back_rearm: got st=%0d, want 1", st0);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; ack = 1'b0;
    test_reset();
    test_basic_run();
    test_overrun();
    test_stop_last_final3();
    test_abort();
    test_reset_in_final();
    test_done_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1);
  end
endmodule
